deserializer: RTL and testbench

Collects N_SAMPLES consecutive BIT_WIDTH-bit words from a val/rdy stream and presents them together as one parallel frame on a val/rdy output. It is the receive-side counterpart of the serializer: it sits at the far end of a serial word link and rebuilds the sample vector for downstream parallel consumers such as FFT or buffer blocks. Word i of a frame is the i-th word accepted, with i starting at 0.

---
 rtl/deserializer_pkg.sv | 14 +
 rtl/deserializer_control.sv | 48 ++++
 rtl/reg_rst_en.sv | 17 +
 rtl/deserializer.sv | 50 +++++
 tb/tb_deserializer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/deserializer_pkg.sv
// Shared definitions for the deserializer: FSM state encoding and counter sizing.
package deserializer_pkg;

  typedef logic [0:0] state_t;

  localparam state_t RECV = 1'b0;
  localparam state_t SEND = 1'b1;

  // Word-index counter width; a 2-sample frame still needs one bit.
  function automatic int count_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/deserializer_control.sv
// Frame-assembly FSM: counts accepted words and steers each one to its slot.
module deserializer_control
  import deserializer_pkg::*;
#(
  parameter int N_SAMPLES = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                recv_val,
  input  logic                                send_rdy,
  output logic                                recv_rdy,
  output logic                                send_val,
  output logic [count_width(N_SAMPLES)-1:0]   count,
  output logic [N_SAMPLES-1:0]                wen
);

  localparam int            CW   = count_width(N_SAMPLES);
  localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);

  state_t state;
  logic   recv_fire;
  logic   send_fire;

  assign recv_rdy  = (state == RECV);
  assign send_val  = (state == SEND);
  assign recv_fire = recv_rdy && recv_val;
  assign send_fire = send_val && send_rdy;

  // One-hot slot select, only on an accepted word.
  assign wen = recv_fire ? (N_SAMPLES'(1) << count) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RECV;
      count <= '0;
    end else if (recv_fire) begin
      if (count == LAST) begin
        count <= '0;
        state <= SEND;
      end else begin
        count <= count + CW'(1);
      end
    end else if (send_fire) begin
      state <= RECV;
    end
  end

endmodule

// File: rtl/reg_rst_en.sv
// Resettable, enabled register primitive (synchronous active-high reset).
module reg_rst_en #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/deserializer.sv
// Rebuilds N_SAMPLES serial words into one parallel frame on a val/rdy output.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES],
  output logic                 send_val,
  input  logic                 send_rdy
);

  logic [count_width(N_SAMPLES)-1:0] count;
  logic [N_SAMPLES-1:0]              wen;

  deserializer_control #(
    .N_SAMPLES (N_SAMPLES)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .send_rdy (send_rdy),
    .recv_rdy (recv_rdy),
    .send_val (send_val),
    .count    (count),
    .wen      (wen)
  );

  for (genvar i = 0; i < N_SAMPLES; i++) begin : g_sample
    reg_rst_en #(
      .WIDTH (BIT_WIDTH)
    ) u_reg (
      .clk   (clk),
      .reset (reset),
      .en    (wen[i]),
      .d     (recv_msg),
      .q     (send_msg[i])
    );
  end

  // The write strobe must always target the slot the counter points at.
  assert property (@(posedge clk) disable iff (reset)
                   (wen == '0) || (wen == (N_SAMPLES'(1) << count)));

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: an 8x32 instance and a 5x16 instance against a queue-based frame model.
module tb_deserializer;

  logic        clk = 1'b0;
  logic        reset;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  logic [31:0] recv_msg8;
  logic        recv_val8, recv_rdy8, send_val8, send_rdy8;
  logic [31:0] send_msg8 [8];

  logic [15:0] recv_msg5;
  logic        recv_val5, recv_rdy5, send_val5, send_rdy5;
  logic [15:0] send_msg5 [5];

  always #5 clk = ~clk;

  deserializer #(.BIT_WIDTH(32), .N_SAMPLES(8)) dut8 (
    .clk(clk), .reset(reset), .recv_msg(recv_msg8), .recv_val(recv_val8),
    .recv_rdy(recv_rdy8), .send_msg(send_msg8), .send_val(send_val8), .send_rdy(send_rdy8));

  deserializer #(.BIT_WIDTH(16), .N_SAMPLES(5)) dut5 (
    .clk(clk), .reset(reset), .recv_msg(recv_msg5), .recv_val(recv_val5),
    .recv_rdy(recv_rdy5), .send_msg(send_msg5), .send_val(send_val5), .send_rdy(send_rdy5));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: a queue of accepted words becomes a pending frame once full.
  logic [31:0] acc8 [$];
  logic [31:0] frame8 [8];
  bit          pend8;
  int          fire_last = 0, fire_prev = 0;
  logic [15:0] acc5 [$];
  logic [15:0] frame5 [5];
  bit          pend5;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      acc8.delete(); pend8 = 0;
      acc5.delete(); pend5 = 0;
    end else begin
      if (pend8) begin
        if (send_rdy8) begin
          pend8 = 0; fire_prev = fire_last; fire_last = cyc;
        end
      end else if (recv_val8) begin
        acc8.push_back(recv_msg8);
        if (acc8.size() == 8) begin
          foreach (frame8[i]) frame8[i] = acc8[i];
          acc8.delete(); pend8 = 1;
        end
      end
      if (pend5) begin
        if (send_rdy5) pend5 = 0;
      end else if (recv_val5) begin
        acc5.push_back(recv_msg5);
        if (acc5.size() == 5) begin
          foreach (frame5[i]) frame5[i] = acc5[i];
          acc5.delete(); pend5 = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("recv_rdy8", recv_rdy8, !pend8);
      check("send_val8", send_val8, pend8);
      check("count8", dut8.u_ctrl.count, pend8 ? 0 : acc8.size());
      if (pend8) for (int i = 0; i < 8; i++) check($sformatf("send_msg8[%0d]", i), send_msg8[i], frame8[i]);
      check("recv_rdy5", recv_rdy5, !pend5);
      check("send_val5", send_val5, pend5);
      check("count5", dut5.u_ctrl.count, pend5 ? 0 : acc5.size());
      if (pend5) for (int i = 0; i < 5; i++) check($sformatf("send_msg5[%0d]", i), send_msg5[i], frame5[i]);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push8(input logic [31:0] w);
    logic f;
    recv_val8 = 1'b1; recv_msg8 = w;
    for (int k = 0; k < 50; k++) begin
      f = recv_rdy8;
      step();
      if (f) return;
    end
    n_checks++; n_fail++;
    $display("FAIL push8_timeout: word %0h, recv_rdy never seen high", w);
  endtask

  task automatic push5(input logic [15:0] w);
    logic f;
    recv_val5 = 1'b1; recv_msg5 = w;
    for (int k = 0; k < 50; k++) begin
      f = recv_rdy5;
      step();
      if (f) return;
    end
    n_checks++; n_fail++;
    $display("FAIL push5_timeout: word %0h, recv_rdy never seen high", w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] w5 [5];
    w5 = '{16'hFFFF, 16'h0000, 16'h1234, 16'h0001, 16'h8000};
    reset = 1'b1;
    recv_msg8 = '0; recv_val8 = 1'b0; send_rdy8 = 1'b0;
    recv_msg5 = '0; recv_val5 = 1'b0; send_rdy5 = 1'b0;
    step(); step();
    reset = 1'b0;

    check("reset_recv_rdy8", recv_rdy8, 1);
    check("reset_send_val8", send_val8, 0);
    for (int i = 0; i < 8; i++) check($sformatf("reset_msg8[%0d]", i), send_msg8[i], 0);
    check("reset_recv_rdy5", recv_rdy5, 1);
    check("reset_send_val5", send_val5, 0);

    // Basic frame
    send_rdy8 = 1'b1;
    for (int i = 0; i < 8; i++) push8(32'h11 * (i + 1));
    recv_val8 = 1'b0;
    check("basic_send_val", send_val8, 1);
    check("basic_recv_rdy", recv_rdy8, 0);
    check("basic_msg0", send_msg8[0], 32'h11);
    check("basic_msg7", send_msg8[7], 32'h88);
    step();
    check("basic_one_cycle", send_val8, 0);
    check("basic_rdy_back", recv_rdy8, 1);

    // Gapped input
    for (int i = 0; i < 8; i++) begin
      push8(32'h11 * (i + 1));
      if (i < 7) begin recv_val8 = 1'b0; step(); end
    end
    recv_val8 = 1'b0;
    check("gap_send_val", send_val8, 1);
    check("gap_msg3", send_msg8[3], 32'h44);
    step();

    // Backpressure, with a word offered while the frame is held
    send_rdy8 = 1'b0;
    for (int i = 0; i < 8; i++) push8(32'hB0 + i);
    recv_val8 = 1'b1; recv_msg8 = 32'hDEAD;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_send_val", send_val8, 1);
      check("bp_msg0", send_msg8[0], 32'hB0);
    end
    send_rdy8 = 1'b1; recv_val8 = 1'b0;
    step();
    check("bp_released", send_val8, 0);

    // Two frames back to back
    for (int i = 1; i <= 16; i++) begin
      push8(i);
      if (i == 8) begin
        check("two_a_msg0", send_msg8[0], 1);
        check("two_a_msg7", send_msg8[7], 8);
      end
    end
    recv_val8 = 1'b0;
    check("two_b_msg0", send_msg8[0], 9);
    check("two_b_msg7", send_msg8[7], 16);
    step();
    check("two_fire_gap", fire_last - fire_prev, 9);

    // Reset mid-frame
    for (int i = 0; i < 3; i++) push8(32'hC1 + i);
    recv_val8 = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_recv_rdy", recv_rdy8, 1);
    check("rst_send_val", send_val8, 0);
    check("rst_count", dut8.u_ctrl.count, 0);
    for (int i = 0; i < 8; i++) check($sformatf("rst_msg8[%0d]", i), send_msg8[i], 0);
    for (int i = 0; i < 8; i++) push8(32'hA0 + i);
    recv_val8 = 1'b0;
    check("rst_frame_msg0", send_msg8[0], 32'hA0);
    check("rst_frame_msg7", send_msg8[7], 32'hA7);
    step();

    // Non-power-of-two sizing
    send_rdy5 = 1'b1;
    for (int i = 0; i < 5; i++) push5(w5[i]);
    recv_val5 = 1'b0;
    check("n5_send_val", send_val5, 1);
    check("n5_count_wrap", dut5.u_ctrl.count, 0);
    check("n5_msg0", send_msg5[0], 16'hFFFF);
    check("n5_msg1", send_msg5[1], 16'h0000);
    check("n5_msg2", send_msg5[2], 16'h1234);
    check("n5_msg3", send_msg5[3], 16'h0001);
    check("n5_msg4", send_msg5[4], 16'h8000);
    step();
    check("n5_released", send_val5, 0);
    check("n5_rdy_back", recv_rdy5, 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
